dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder.sv | 158 +++++++++++++++
 tb/tb_dm_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one MEM-stage load/store, waits WAIT_CYCLES, then accesses a word array.
// Optional macro DM_BYTE_LANE_EN makes stores honour req_be; without it req_be is ignored.
module dm_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);
  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic        zero_q;
  logic [31:0] rd_word_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        fault;
  logic [AW-1:0] idx;
  logic        enter_resp;
  logic        wr_en;
  logic        rd_en;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_ready && req_valid;
  assign stall     = (state_q == WAIT) || ((state_q == IDLE) && req_valid);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (NO_WAIT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait the access happens on the acceptance edge, before the latches hold the request.
  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  assign fault      = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_LIM);
  assign idx        = acc_addr[AW+1:2];
  assign enter_resp = !rst && (state_q != RESP) && (state_d == RESP);
  assign wr_en      = enter_resp && acc_we && !fault;
  assign rd_en      = enter_resp && !acc_we && !fault;

`ifdef DM_BYTE_LANE_EN
  logic [3:0] be_q;
  logic [3:0] acc_be;
  assign acc_be = (state_q == IDLE) ? req_be : be_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      be_q <= req_be;
    end
  end
`else
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= enter_resp;
      resp_err_q   <= enter_resp && fault;
      if (enter_resp && fault) begin
        zero_q <= 1'b1;
      end else if (rd_en) begin
        zero_q <= 1'b0;
      end
    end
  end

  // Storage and read register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
`ifdef DM_BYTE_LANE_EN
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem_q[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
`else
      mem_q[idx] <= acc_wdata;
`endif
    end
    if (rd_en) begin
      rd_word_q <= mem_q[idx];
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = zero_q ? 32'h0 : rd_word_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance share one request bus,
// checked against a word-array model of the load/store/fault rules.
module tb_dm_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        ready2, rv2, err2, stall2;
  logic [31:0] rd2;
  logic        ready0, rv0, err0, stall0;
  logic [31:0] rd0;

  int total = 0;
  int bad   = 0;

  logic [31:0] m2 [1024];
  logic [31:0] m0 [1024];
  logic [31:0] hold2, hold0;

  always #5 clk = ~clk;

  dm_responder u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv2), .resp_rdata(rd2), .resp_err(err2), .stall(stall2)
  );

  dm_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0), .stall(stall0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic is_fault(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 1024);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = nw;
`ifdef DM_BYTE_LANE_EN
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
`else
    if (be === 4'bxxxx) r = old;
`endif
    return r;
  endfunction

  // One request issued at a negedge while both instances idle; observed for 5 cycles after acceptance.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic f;
    logic [9:0] wi;
    logic [31:0] nh2, nh0;
    f   = is_fault(a);
    wi  = a[11:2];
    nh2 = f ? 32'h0 : (we ? hold2 : m2[wi]);
    nh0 = f ? 32'h0 : (we ? hold0 : m0[wi]);
    if (we && !f) begin
      m2[wi] = merge(m2[wi], wd, be);
      m0[wi] = merge(m0[wi], wd, be);
    end
    req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
    #1;
    chk("ready2_idle", 32'(ready2), 32'd1);
    chk("ready0_idle", 32'(ready0), 32'd1);
    chk("stall2_req", 32'(stall2), 32'd1);
    chk("stall0_req", 32'(stall0), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      chk("rv2", 32'(rv2), 32'(c == 3));
      chk("rv0", 32'(rv0), 32'(c == 1));
      chk("stall2", 32'(stall2), 32'(c < 3));
      chk("stall0", 32'(stall0), 32'd0);
      chk("ready2", 32'(ready2), 32'(c >= 4));
      chk("ready0", 32'(ready0), 32'(c >= 2));
      chk("err2", 32'(err2), 32'((c == 3) && f));
      chk("err0", 32'(err0), 32'((c == 1) && f));
      chk("rdata2", rd2, (c >= 3) ? nh2 : hold2);
      chk("rdata0", rd0, (c >= 1) ? nh0 : hold0);
    end
    $display("xact we=%0d addr=%h wdata=%h be=%b fault=%0d rdata2=%h rdata0=%h",
             we, a, wd, be, f, rd2, rd0);
    hold2 = nh2;
    hold0 = nh0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pool [8] = '{0, 1, 2, 4, 8, 16, 511, 1023};
    logic [31:0] a;
    int k;

    // Reset with a request pending: it must not be accepted.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'hF;
    hold2 = 32'h0; hold0 = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rv2", 32'(rv2), 32'd0);
    chk("rst_err2", 32'(err2), 32'd0);
    chk("rst_rd2", rd2, 32'h0);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_ready2", 32'(ready2), 32'd1);
    chk("rst_stall2", 32'(stall2), 32'd1);
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_ready2", 32'(ready2), 32'd1);
    chk("post_rst_stall2", 32'(stall2), 32'd0);
    chk("post_rst_rv0", 32'(rv0), 32'd0);

    // Store then load, misaligned and out-of-range faults, top word boundary.
    xact(1'b1, 32'h0000_0000, 32'hCAFE_0000, 4'hF);
    xact(1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF);
    xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    xact(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    chk("load_deadbeef", rd2, 32'hDEAD_BEEF);
    xact(1'b0, 32'h0000_0012, 32'h0, 4'hF);
    xact(1'b1, 32'h0000_1000, 32'h5A5A_5A5A, 4'hF);
    xact(1'b0, 32'h0000_0000, 32'h0, 4'hF);
    chk("word0_intact", rd2, 32'hCAFE_0000);
    xact(1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'hF);
    xact(1'b0, 32'h0000_0FFC, 32'h0, 4'hF);

    // Byte lanes.
    xact(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF);
    xact(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
    xact(1'b0, 32'h0000_0020, 32'h0, 4'b0000);
`ifdef DM_BYTE_LANE_EN
    chk("lane_merge", rd2, 32'h11BB_33DD);
`else
    chk("lane_merge", rd2, 32'hAABB_CCDD);
`endif
    xact(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000);
    xact(1'b0, 32'h0000_0020, 32'h0, 4'hF);

    // Reset in the second WAIT cycle discards the store on the waiting instance.
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_be = 4'hF; req_valid = 1'b1;
    m0[16] = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rstw_rv2_c1", 32'(rv2), 32'd0);
    chk("rstw_rv0_c1", 32'(rv0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_rv2_c2", 32'(rv2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_rv2_c3", 32'(rv2), 32'd0);
    chk("rstw_ready2", 32'(ready2), 32'd1);
    chk("rstw_rd2", rd2, 32'h0);
    chk("rstw_rd0", rd0, 32'h0);
    hold2 = 32'h0; hold0 = 32'h0;
    xact(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    chk("rstw_old2", rd2, 32'h1234_5678);
    chk("rstw_new0", rd0, 32'h0000_0055);

    // Back-to-back loads with req_valid held high.
    req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("b2b_ready2", 32'(ready2), 32'(c % 4 == 0));
      chk("b2b_rv2", 32'(rv2), 32'(c % 4 == 3));
      chk("b2b_stall2", 32'(stall2), 32'(c % 4 != 3));
      chk("b2b_ready0", 32'(ready0), 32'(c % 2 == 0));
      chk("b2b_rv0", 32'(rv0), 32'(c % 2 == 1));
      chk("b2b_stall0", 32'(stall0), 32'(c % 2 == 0));
      if (c % 4 == 3) chk("b2b_rd2", rd2, m2[4]);
      if (c % 2 == 1) chk("b2b_rd0", rd0, m0[4]);
      @(negedge clk);
    end
    req_valid = 1'b0;
    hold2 = m2[4]; hold0 = m0[4];
    @(negedge clk);

    // Random traffic over a small word pool, with occasional faults.
    for (int i = 0; i < 8; i++) xact(1'b1, 32'(pool[i]) * 4, $urandom, 4'hF);
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 7);
      case ($urandom_range(0, 9))
        0:       a = 32'(pool[k]) * 4 + 32'($urandom_range(1, 3));
        1:       a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        default: a = 32'(pool[k]) * 4;
      endcase
      xact(1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
